// File: rtl/demultiplexer_reg_pkg.sv
// Shared constants and types for the 8:1 word multiplexer / 1:8 demultiplexer pair.
package demultiplexer_reg_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;
    localparam int LANES  = 8;
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demultiplexer_reg_if.sv
// Producer-side and consumer-side handshake bundle of the registered 1:8 distributor.
interface demultiplexer_reg_if #(
    parameter int WIDTH = demultiplexer_reg_pkg::DATA_W,
    parameter int LANES = demultiplexer_reg_pkg::LANES,
    parameter int SEL_W = demultiplexer_reg_pkg::SEL_W,
    parameter int CNT_W = demultiplexer_reg_pkg::CNT_W
);

    logic [WIDTH-1:0]       inData;
    logic [SEL_W-1:0]       selectLine;
    logic                   inValid;
    logic                   inReady;
    logic [WIDTH*LANES-1:0] outData;
    logic [LANES-1:0]       outValid;
    logic [LANES-1:0]       outReady;
    logic [CNT_W-1:0]       acceptCount;

    modport master (
        output inData, selectLine, inValid, outReady,
        input  inReady, outData, outValid, acceptCount
    );

    modport slave (
        input  inData, selectLine, inValid, outReady,
        output inReady, outData, outValid, acceptCount
    );

endinterface

// File: rtl/demux_lane_slot.sv
// Single-entry output lane: one data register plus an EMPTY/FULL occupancy machine.
module demux_lane_slot
    import demultiplexer_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] loadData,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    slot_state_e state;
    slot_state_e nextState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // A load in the same cycle as a drain wins, so the lane stays full.
    always_comb begin
        nextState = state;
        case (state)
            SLOT_EMPTY: if (load) nextState = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) nextState = SLOT_EMPTY;
            default:    nextState = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= loadData;
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demultiplexer_reg.sv
// Registered 1:8 distributor: steers one word per accept into the lane picked by selectLine.
module demultiplexer_reg #(
    parameter int WIDTH = demultiplexer_reg_pkg::DATA_W,
    parameter int LANES = demultiplexer_reg_pkg::LANES,
    parameter int SEL_W = demultiplexer_reg_pkg::SEL_W,
    parameter int CNT_W = demultiplexer_reg_pkg::CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    demultiplexer_reg_if.slave bus
);

    logic                   inReady;
    logic                   accept;
    logic [LANES-1:0]       loadVec;
    logic [LANES-1:0]       laneValid;
    logic [WIDTH*LANES-1:0] laneData;
    logic [CNT_W-1:0]       acceptCount;

    // Only the addressed lane can stall the producer; other full lanes are irrelevant.
    assign inReady = rst_n & (~laneValid[bus.selectLine] | bus.outReady[bus.selectLine]);
    assign accept  = bus.inValid & inReady;

    always_comb begin
        loadVec = '0;
        loadVec[bus.selectLine] = accept;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (loadVec[k]),
            .loadData (bus.inData),
            .drain    (bus.outReady[k]),
            .data     (laneData[k*WIDTH +: WIDTH]),
            .valid    (laneValid[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acceptCount <= '0;
        end else if (accept) begin
            acceptCount <= acceptCount + 1'b1;
        end
    end

    assign bus.inReady     = inReady;
    assign bus.outData     = laneData;
    assign bus.outValid    = laneValid;
    assign bus.acceptCount = acceptCount;

endmodule

// File: tb/tb_demultiplexer_reg.sv
// Self-checking bench for demultiplexer_reg: directed scenarios plus randomized traffic vs. a lane model.
module tb_demultiplexer_reg;

    logic clk;
    logic rst_n;

    demultiplexer_reg_if                bus();
    demultiplexer_reg_if #(.CNT_W(4))   busW();

    demultiplexer_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    demultiplexer_reg #(.CNT_W(4)) dutWrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busW)
    );

    assign busW.inData     = bus.inData;
    assign busW.selectLine = bus.selectLine;
    assign busW.inValid    = bus.inValid;
    assign busW.outReady   = bus.outReady;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mData  [8];
    logic        mValid [8];
    int unsigned mCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 8; k++) begin
            mData[k]  = 32'h0;
            mValid[k] = 1'b0;
        end
        mCount = 0;
    endtask

    task automatic verifyState(input string tag);
        logic [7:0] expValid;
        for (int k = 0; k < 8; k++) expValid[k] = mValid[k];
        checkOutput({tag, "_valid"}, 64'(bus.outValid), 64'(expValid));
        checkOutput({tag, "_wvalid"}, 64'(busW.outValid), 64'(expValid));
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_data%0d", tag, k), 64'(bus.outData[k*32 +: 32]), 64'(mData[k]));
            checkOutput($sformatf("%s_wdata%0d", tag, k), 64'(busW.outData[k*32 +: 32]), 64'(mData[k]));
        end
        checkOutput({tag, "_count"}, 64'(bus.acceptCount), 64'(mCount % 65536));
        checkOutput({tag, "_wcount"}, 64'(busW.acceptCount), 64'(mCount % 16));
    endtask

    // One clock of traffic: drive at the falling edge, check inReady mid-cycle, update the model at the rising edge.
    task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [31:0] data,
                                 input logic [7:0] rdy, output logic accepted);
        logic expReady;
        @(negedge clk);
        bus.inValid    = v;
        bus.selectLine = sel;
        bus.inData     = data;
        bus.outReady   = rdy;
        #1;
        expReady = !mValid[sel] || rdy[sel];
        checkOutput("inReady", 64'(bus.inReady), 64'(expReady));
        checkOutput("wInReady", 64'(busW.inReady), 64'(expReady));
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (mValid[k] && rdy[k]) mValid[k] = 1'b0;
        end
        accepted = v && expReady;
        if (accepted) begin
            mData[sel]  = data;
            mValid[sel] = 1'b1;
            mCount++;
        end
        #1;
        verifyState("cyc");
    endtask

    initial begin
        logic        acc;
        logic        hold;
        logic        v;
        logic [2:0]  sel;
        logic [31:0] d;

        rst_n          = 1'b0;
        bus.inValid    = 1'b0;
        bus.selectLine = 3'd0;
        bus.inData     = 32'h0;
        bus.outReady   = 8'h00;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_inReady", 64'(bus.inReady), 64'd0);
        verifyState("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_inReady", 64'(bus.inReady), 64'd1);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 3'(k), 32'(100 + k), 8'hFF, acc);
            checkOutput($sformatf("sweep_acc%0d", k), 64'(acc), 64'd1);
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, acc);
        checkOutput("sweep_count", 64'(bus.acceptCount), 64'd8);

        applyStimulus(1'b1, 3'd3, 32'hA5A5_0001, 8'h00, acc);
        applyStimulus(1'b1, 3'd3, 32'hA5A5_0002, 8'h00, acc);
        checkOutput("bp_stall", 64'(acc), 64'd0);
        applyStimulus(1'b1, 3'd4, 32'hA5A5_0004, 8'h00, acc);
        checkOutput("bp_lane4", 64'(acc), 64'd1);
        applyStimulus(1'b1, 3'd5, 32'hA5A5_0005, 8'h00, acc);
        checkOutput("bp_lane5", 64'(acc), 64'd1);
        checkOutput("bp_hold3", 64'(bus.outData[3*32 +: 32]), 64'h0000_0000_A5A5_0001);
        applyStimulus(1'b1, 3'd3, 32'hA5A5_0002, 8'h08, acc);
        checkOutput("bp_release", 64'(acc), 64'd1);
        checkOutput("bp_new3", 64'(bus.outData[3*32 +: 32]), 64'h0000_0000_A5A5_0002);

        applyStimulus(1'b1, 3'd6, 32'h1111_6666, 8'h00, acc);
        applyStimulus(1'b1, 3'd6, 32'hDEAD_BEEF, 8'h40, acc);
        checkOutput("same_acc", 64'(acc), 64'd1);
        checkOutput("same_valid6", 64'(bus.outValid[6]), 64'd1);
        checkOutput("same_data6", 64'(bus.outData[6*32 +: 32]), 64'h0000_0000_DEAD_BEEF);

        applyStimulus(1'b1, 3'd1, 32'h0000_0101, 8'h00, acc);
        applyStimulus(1'b1, 3'd2, 32'h0000_0202, 8'h00, acc);
        @(negedge clk);
        bus.inValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(bus.outValid), 64'd0);
        checkOutput("arst_count", 64'(bus.acceptCount), 64'd0);
        checkOutput("arst_inReady", 64'(bus.inReady), 64'd0);
        modelReset();
        verifyState("arst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd1, 32'h0000_1234, 8'h00, acc);
        checkOutput("arst_first", 64'(bus.outValid), 64'h02);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 3'd0, 32'(i), 8'hFF, acc);
        end
        checkOutput("wrap_count", 64'(busW.acceptCount), 64'd1);
        checkOutput("wrap_full", 64'(bus.acceptCount), 64'd17);

        hold = 1'b0;
        v    = 1'b0;
        sel  = 3'd0;
        d    = 32'h0;
        for (int i = 0; i < 300; i++) begin
            if (!hold) begin
                v   = ($urandom_range(0, 3) != 0);
                sel = 3'($urandom_range(0, 7));
                d   = $urandom;
            end
            applyStimulus(v, sel, d, 8'($urandom), acc);
            hold = v && !acc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
